// File: rtl/life_gen_sequencer.sv
// Generation sequencer for the 8x8 life grid: seed load, single step, rate-divided free-run, auto-halt.
// Optional LIFE_OSC_DETECT_EN adds period-2 oscillation detection (prev_grid register, osc halt).
module life_gen_sequencer #(
  parameter int unsigned GEN_W = 16,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      seed,
  input  logic             load,
  input  logic             run,
  input  logic             step,
  input  logic [GEN_W-1:0] max_gens,
  input  logic [DIV_W-1:0] rate,
  output logic [63:0]      dp_in,
  input  logic [63:0]      dp_out,
  output logic [63:0]      grid,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy,
  output logic             done,
  output logic             stable,
  output logic             extinct,
  output logic             osc
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [GEN_W-1:0] gen_inc;
  logic             run_evolve;
  logic             idle_evolve;
  logic             evolve;
  logic             osc_hit;
  logic             halt_hit;

  assign dp_in       = grid;
  assign busy        = (state_q == StRun);
  assign gen_inc     = (&gen_count) ? gen_count : gen_count + 1'b1;
  assign run_evolve  = (state_q == StRun) && run && (div_q >= rate);
  assign idle_evolve = (state_q == StIdle) && !run && step;
  assign evolve      = !load && (run_evolve || idle_evolve);

`ifdef LIFE_OSC_DETECT_EN
  logic [63:0] prev_grid_q;
  logic        osc_q;

  // gen_count gate keeps the cleared prev_grid from matching an all-zero successor
  assign osc_hit = (dp_out == prev_grid_q) && (gen_count != '0);
  assign osc     = osc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_grid_q <= '0;
      osc_q       <= 1'b0;
    end else if (load) begin
      prev_grid_q <= '0;
      osc_q       <= 1'b0;
    end else if (evolve) begin
      prev_grid_q <= grid;
      osc_q       <= osc_hit;
    end
  end
`else
  assign osc_hit = 1'b0;
  assign osc     = 1'b0;
`endif

  assign halt_hit = ((max_gens != '0) && (gen_inc == max_gens)) ||
                    (dp_out == grid) || (dp_out == '0) || osc_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      grid      <= '0;
      gen_count <= '0;
      done      <= 1'b0;
      stable    <= 1'b0;
      extinct   <= 1'b0;
    end else if (load) begin
      // run is deliberately not honoured on the load edge
      state_q   <= StIdle;
      div_q     <= '0;
      grid      <= seed;
      gen_count <= '0;
      done      <= 1'b0;
      stable    <= 1'b0;
      extinct   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q <= StRun;
            div_q   <= '0;
          end
        end
        StRun: begin
          if (!run) begin
            state_q <= StIdle;
          end else if (div_q >= rate) begin
            div_q <= '0;
            if (halt_hit) begin
              state_q <= StHalt;
              done    <= 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StHalt: ;
        default: state_q <= StIdle;
      endcase
      if (evolve) begin
        grid      <= dp_out;
        gen_count <= gen_inc;
        stable    <= (dp_out == grid);
        extinct   <= (dp_out == '0);
      end
    end
  end

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Scoreboard bench for life_gen_sequencer: a driver pushes model predictions, a monitor pops and compares.
module tb_life_gen_sequencer;

  logic        clk;
  logic        reset;
  logic [63:0] seed;
  logic        load, run, step;
  logic [15:0] max_gens;
  logic [7:0]  rate;
  logic [63:0] dp_in, dp_out, grid;
  logic [15:0] gen_count;
  logic        busy, done, stable, extinct, osc;

  int n_vec;
  int n_err;

  typedef struct packed {
    logic [63:0] grid;
    logic [15:0] gen;
    logic        busy;
    logic        done;
    logic        stable;
    logic        ext;
    logic        osc;
  } exp_t;

  exp_t exp_q[$];

  life_gen_sequencer #(.GEN_W(16), .DIV_W(8)) dut (
    .clk(clk), .reset(reset), .seed(seed), .load(load), .run(run), .step(step),
    .max_gens(max_gens), .rate(rate), .dp_in(dp_in), .dp_out(dp_out), .grid(grid),
    .gen_count(gen_count), .busy(busy), .done(done), .stable(stable), .extinct(extinct),
    .osc(osc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Conway rule on a bounded 8x8 board (cells outside are dead)
  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
              cnt += int'(g[rr*8+cc]);
          end
        end
        n[r*8+c] = (cnt == 3) || (g[r*8+c] && cnt == 2);
      end
    end
    return n;
  endfunction

  assign dp_out = life_next(dp_in);

  // Reference model
  localparam int MIdle = 0, MRun = 1, MHalt = 2;
  int          m_mode;
  int          m_div;
  logic [63:0] m_grid, m_prev;
  int          m_gen;
  logic        m_done, m_stable, m_ext, m_osc;

  task automatic m_evolve(input bit in_run, input int mg);
    logic [63:0] nxt;
    int          ngen;
    bit          osc_hit, stop;
    nxt  = life_next(m_grid);
    ngen = (m_gen == 65535) ? 65535 : m_gen + 1;
    osc_hit = 1'b0;
`ifdef LIFE_OSC_DETECT_EN
    osc_hit = (nxt == m_prev) && (m_gen >= 1);
`endif
    stop = (mg != 0 && ngen == mg) || (nxt == m_grid) || (nxt == 64'd0) || osc_hit;
    m_stable = (nxt == m_grid);
    m_ext    = (nxt == 64'd0);
    m_osc    = osc_hit;
    m_prev   = m_grid;
    m_grid   = nxt;
    m_gen    = ngen;
    if (in_run && stop) begin
      m_mode = MHalt;
      m_done = 1'b1;
    end
  endtask

  task automatic m_clear();
    m_mode = MIdle; m_div = 0; m_gen = 0; m_prev = '0;
    m_done = 0; m_stable = 0; m_ext = 0; m_osc = 0;
  endtask

  task automatic cyc(input bit rs, input bit ld, input bit rn, input bit st,
                     input logic [63:0] sd, input logic [15:0] mg, input logic [7:0] rt);
    exp_t e;
    @(negedge clk);
    reset = rs; load = ld; run = rn; step = st; seed = sd; max_gens = mg; rate = rt;
    if (!rs) begin
      m_clear();
      m_grid = '0;
    end else if (ld) begin
      m_clear();
      m_grid = sd;
    end else begin
      case (m_mode)
        MIdle: begin
          if (rn) begin
            m_mode = MRun;
            m_div  = 0;
          end else if (st) m_evolve(1'b0, int'(mg));
        end
        MRun: begin
          if (!rn) m_mode = MIdle;
          else if (m_div >= int'(rt)) begin
            m_div = 0;
            m_evolve(1'b1, int'(mg));
          end else m_div++;
        end
        default: ;
      endcase
    end
    e.grid = m_grid; e.gen = 16'(m_gen); e.busy = (m_mode == MRun); e.done = m_done;
    e.stable = m_stable; e.ext = m_ext; e.osc = m_osc;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  // Monitor: one prediction per clock, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grid", grid, e.grid);
        chk("gen_count", 64'(gen_count), 64'(e.gen));
        chk("busy", 64'(busy), 64'(e.busy));
        chk("done", 64'(done), 64'(e.done));
        chk("stable", 64'(stable), 64'(e.stable));
        chk("extinct", 64'(extinct), 64'(e.ext));
        chk("osc", 64'(osc), 64'(e.osc));
      end
    end
  end

  localparam logic [63:0] Blinker = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] Block   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] Single  = 64'h0000_0000_0000_0001;

  initial begin
    bit          rn;
    logic [63:0] sd;
    logic [15:0] mg;
    logic [7:0]  rt;
    n_vec = 0; n_err = 0;
    reset = 1'b0; load = 0; run = 0; step = 0; seed = '0; max_gens = '0; rate = '0;
    m_clear();
    m_grid = '0;
    cyc(0, 0, 0, 0, '0, 0, 0);
    cyc(1, 0, 0, 0, '0, 0, 0);
    // Blinker single step
    cyc(1, 1, 0, 0, Blinker, 0, 0);
    cyc(1, 0, 0, 1, '0, 0, 0);
    cyc(1, 0, 0, 0, '0, 0, 0);
    // Block is stable: one evolve then halt
    cyc(1, 1, 0, 0, Block, 0, 0);
    repeat (4) cyc(1, 0, 1, 1, '0, 0, 0);
    // Rate divider with generation target
    cyc(1, 1, 0, 0, Blinker, 5, 3);
    repeat (25) cyc(1, 0, 1, 0, '0, 5, 3);
    // Extinction, then load+run together
    cyc(1, 1, 0, 0, Single, 0, 0);
    repeat (3) cyc(1, 0, 1, 0, '0, 0, 0);
    cyc(1, 1, 1, 0, Blinker, 0, 0);
    cyc(1, 0, 1, 0, '0, 0, 1);
    cyc(1, 0, 0, 0, '0, 0, 1);
    // Unlimited blinker free-run
    cyc(1, 1, 0, 0, Blinker, 0, 0);
    repeat (100) cyc(1, 0, 1, 0, '0, 0, 0);
    // Asynchronous reset mid-run
    cyc(1, 1, 0, 0, Blinker, 0, 2);
    repeat (6) cyc(1, 0, 1, 0, '0, 0, 2);
    cyc(0, 0, 1, 0, '0, 0, 2);
    cyc(1, 0, 0, 0, '0, 0, 0);
    // Randomized traffic
    rn = 0; mg = 0; rt = 0;
    for (int i = 0; i < 800; i++) begin
      sd = {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 19) == 0) rn = !rn;
      if ($urandom_range(0, 39) == 0) mg = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) rt = 8'($urandom_range(0, 3));
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 24) == 0), rn,
          ($urandom_range(0, 3) == 0), sd, mg, rt);
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/life_gen_sequencer.md
Name: life_gen_sequencer

Overview:
- Sequences generation stepping of the 8x8 (64-bit) life grid.
- Owns the grid state register and drives the combinational next-generation datapath. Captures the datapath result on scheduled evolve events.
- Supports seed load, single-step, and free-run at a programmable generation rate.
- Auto-halts on a generation target or on a stable or extinct grid; reports status to the top level.

Parameters:
- GEN_W, 16, width of generation counter and max_gens.
- DIV_W, 8, width of rate divider and rate input.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- seed  in  64  initial grid, bit index = row*8+col.
- load  in  1  copy seed into grid.
- run  in  1  level; free-run enable.
- step  in  1  single-generation request, one-cycle pulse.
- max_gens  in  GEN_W  generation target; 0 = unlimited.
- rate  in  DIV_W  one evolve every rate+1 clocks while running.
- dp_in  out  64  current grid presented to datapath (= grid).
- dp_out  in  64  next generation returned combinationally by datapath.
- grid  out  64  registered current grid.
- gen_count  out  GEN_W  generations since last load; saturates at all-ones.
- busy  out  1  high in RUN.
- done  out  1  sticky; set on entry to HALT.
- stable  out  1  last evolve produced dp_out == previous grid.
- extinct  out  1  last evolve produced all-zero grid.
- osc  out  1  period-2 oscillation detected (see Optional Feature).

Behaviour:
- Reset (reset=0, async): grid=0, gen_count=0, divider=0, state=IDLE; busy, done, stable, extinct, osc all 0.
- Evolve event (single edge):
  - grid<=dp_out; gen_count+1 (saturating).
  - stable<=(dp_out==grid); extinct<=(dp_out==0).
- Latency: an input sampled at edge k takes effect at edge k; grid is valid after edge k.
- Priority each cycle: load > run > step.
- Load, from any state:
  - grid<=seed; gen_count, divider, done, stable, extinct, osc cleared.
  - Next state = IDLE, even if run is high; run is honoured from the following cycle.
- IDLE:
  - run=1 -> RUN, divider=0, no evolve this edge.
  - Else step=1 -> one evolve, stay IDLE.
  - Else hold.
- RUN:
  - divider increments each clock.
  - When divider>=rate: evolve and divider<=0. Using >= means lowering rate mid-run evolves on the next clock.
  - run=0 -> IDLE, no evolve that edge.
  - step is ignored.
- RUN -> HALT with done<=1 on the evolve edge where any of these holds:
  - max_gens!=0 and new gen_count==max_gens;
  - dp_out==grid (stable, includes extinct-stays-extinct);
  - dp_out==0.
- HALT:
  - grid and flags frozen; run and step ignored.
  - Exit only via load -> IDLE, done cleared.
- IDLE step evolves also update the flags but never set done and never change state. This holds even when a target or stability is reached.
- max_gens changed mid-run: compared with equality only. If already passed, the run continues until another halt condition or run=0.
- Reset asserted mid-run returns to reset values immediately.

Optional Feature:
- Macro: LIFE_OSC_DETECT_EN.
- Defined:
  - Adds a 64-bit prev_grid register: reset 0, cleared on load, loaded with grid on each evolve.
  - Evolve with dp_out==prev_grid and gen_count>=1 (before increment) sets osc=1.
  - In RUN, this also halts (HALT, done=1).
  - In IDLE step, it sets the flag only.
- Undefined: no prev_grid register; osc tied 0; period-2 patterns free-run.

Test Plan:
- Reset=0 mid-RUN with grid nonzero -> next sample: grid=0, gen_count=0, busy=0, done=0, all flags 0.
- Load seed=0x0000_0000_1C00_0000 (horizontal blinker), step -> grid=0x0000_0008_0808_0000, gen_count=1, stable=0. Bench uses a reference datapath model.
- Load block seed=0x0000_0018_1800_0000, run=1, rate=0 -> one evolve, stable=1, state HALT, done=1, gen_count=1, grid unchanged.
- Load blinker, rate=3, max_gens=5, run=1 held -> evolve every 4 clocks; HALT with done=1 and gen_count=5 exactly 20 clocks after RUN entry.
- Load seed=0x0000_0000_0000_0001, run=1, rate=0 -> grid=0, extinct=1, HALT, done=1. Then load+run in the same cycle -> IDLE, done=0; RUN on the next cycle.
- Blinker, max_gens=0, run=1, rate=0:
  - With LIFE_OSC_DETECT_EN -> HALT at gen_count=2, osc=1.
  - Without -> still busy after 100 clocks, osc=0, grid alternating each clock.
